ram_16x8: RTL
=============

RAM_16X8 -- requirements
Module: ram_16x8

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter DB_CYCLES, default 250000, clk cycles a button level must stay stable before it is accepted.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port addr  input  ADDR_W  word address from the memory address register (switch or bus sourced).
REQ-007 SHALL have port prog_en  input  1  high = program mode, low = run mode.
REQ-008 SHALL have port prog_sw  input  DATA_W  data dip switches used in program mode.
REQ-009 SHALL have port prog_btn  input  1  raw, asynchronous, bouncing write pushbutton, high = pressed.
REQ-010 SHALL have port ram_in  input  1  run-mode control: load bus_in into mem[addr].
REQ-011 SHALL have port ram_out  input  1  run-mode control: drive mem[addr] onto bus.
REQ-012 SHALL have port bus_in  input  DATA_W  bus value to be written.
REQ-013 SHALL have port bus_out  output  DATA_W  mem[addr] data toward the bus.
REQ-014 SHALL have port bus_oe  output  1  bus drive enable.
REQ-015 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-016 SHALL have port wr_ack  output  1  one-cycle pulse on each accepted program-mode write.

Function
REQ-017 SHALL hold 2^ADDR_W x DATA_W storage; read is combinational: bus_out = mem[addr] at all times outside CLEAR.
REQ-018 SHALL implement FSM states CLEAR and READY; clr forces CLEAR with sweep index 0.
REQ-019 In CLEAR SHALL write 0 to mem[index] each cycle, index +1, busy=1; after writing index 15 SHALL enter READY next cycle (16 cycles total).
REQ-020 In CLEAR SHALL ignore ram_in, ram_out, prog_btn; bus_oe=0, bus_out=0, wr_ack=0.
REQ-021 SHALL pass prog_btn through a 2-flop synchronizer, then a debounce counter: accepted level changes only after synced level differs from it for DB_CYCLES consecutive cycles; any mismatch break reloads the counter.
REQ-022 SHALL detect rising edge of accepted level; in READY with prog_en=1 this edge SHALL write prog_sw to mem[addr] and pulse wr_ack one cycle, exactly one write per press.
REQ-023 Accepted-level edges occurring in CLEAR or with prog_en=0 SHALL be discarded (no deferred write).
REQ-024 In READY with prog_en=0 and ram_in=1 SHALL write bus_in to mem[addr] on that rising clk edge.
REQ-025 With prog_en=1, ram_in and ram_out SHALL be ignored; bus_oe=0.
REQ-026 bus_oe SHALL equal ram_out & ~prog_en & ~busy (combinational).
REQ-027 ram_in and ram_out both high SHALL write bus_in and show pre-write mem[addr] on bus_out that cycle (read-before-write).
REQ-028 addr change SHALL be reflected on bus_out in the same cycle; writes use addr sampled at the clk edge.
REQ-029 Toggling prog_en mid-debounce SHALL not reset the debouncer.

Reset
REQ-030 On clr: state=CLEAR, index=0, busy=1, wr_ack=0, bus_oe=0, bus_out=0, synchronizer flops and accepted level=0, debounce counter=0.
REQ-031 clr asserted mid-sweep SHALL restart the sweep at index 0; clr during READY SHALL re-zero all 16 words.
REQ-032 Memory contents are only defined after the first complete sweep.

Verification
REQ-033 Release clr -> busy=1 for exactly 16 cycles, then all 16 words read 0x00 via addr 0..15.
REQ-034 prog_en=1, addr=0x3, prog_sw=0xA5, bouncing press (DB_CYCLES=4, glitches of 1-3 cycles) then stable 10 cycles -> single wr_ack pulse, mem[3]=0xA5; release bounce -> no second write.
REQ-035 prog_en=0, addr=0x7, bus_in=0x3C, ram_in=1 one cycle -> mem[7]=0x3C; then ram_out=1 -> bus_oe=1, bus_out=0x3C.
REQ-036 mem[2]=0x11; ram_in=ram_out=1, bus_in=0x22, addr=2 -> bus_out=0x11 during cycle, 0x22 after edge.
REQ-037 clr at sweep index 9 -> busy stays high 16 further cycles from release; press during CLEAR -> no write, no wr_ack.
REQ-038 prog_en=1 with ram_out=1, ram_in=1 -> bus_oe=0, memory unchanged.

Source files
------------

// File: rtl/ram_16x8.sv
// rtl/ram_16x8.sv - 16x8 program/run RAM with power-on clear sweep and debounced write button
module ram_16x8 #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int DB_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              prog_en,
    input  logic [DATA_W-1:0] prog_sw,
    input  logic              prog_btn,
    input  logic              ram_in,
    input  logic              ram_out,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              busy,
    output logic              wr_ack
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DB_CYCLES - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    // button conditioning
    logic              btn_meta;
    logic              btn_sync;
    logic              db_level;
    logic              db_prev;
    logic [DB_W-1:0]   db_cnt;
    logic              prog_rise;

    // write port selection
    logic              prog_wr;
    logic              run_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    // State register and sweep index; clr restarts the sweep from word 0
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= CLEAR;
            index <= '0;
        end else begin
            state <= state_nx;
            index <= index_nx;
        end
    end

    // Next-state logic: walk every word once in CLEAR, then sit in READY
    always_comb begin
        state_nx = state;
        index_nx = index;
        busy     = 1'b0;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                index_nx = index + 1'b1;
                if (index == LAST_INDEX) begin
                    state_nx = READY;
                    index_nx = '0;
                end
            end
            READY: begin
                state_nx = READY;
            end
            default: begin
                state_nx = CLEAR;
                index_nx = '0;
            end
        endcase
    end

    // Two-flop synchronizer for the raw, asynchronous pushbutton
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= prog_btn;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: accept a new level only after it differs for DB_CYCLES straight cycles;
    // runs independently of mode so toggling prog_en never disturbs a press in progress
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_sync != db_level) begin
            if (db_cnt == DB_LAST) begin
                db_level <= btn_sync;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Delayed copy of the accepted level for rising-edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            db_prev <= 1'b0;
        end else begin
            db_prev <= db_level;
        end
    end

    assign prog_rise = db_level & ~db_prev;

    // An edge that is not consumed right now is simply dropped; nothing is queued
    assign prog_wr = (state == READY) & prog_en & prog_rise;
    assign run_wr  = (state == READY) & ~prog_en & ram_in;

    // Write port mux: sweep has priority, then program button, then run-mode bus load
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr;
        mem_data = bus_in;
        if (state == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = index;
            mem_data = '0;
        end else if (prog_wr) begin
            mem_we   = 1'b1;
            mem_data = prog_sw;
        end else if (run_wr) begin
            mem_we   = 1'b1;
        end
    end

    // Storage array; contents are meaningful only once a sweep has completed
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // One-cycle acknowledge, following each accepted program-mode write
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= prog_wr;
        end
    end

    // Asynchronous read gives read-before-write when ram_in and ram_out overlap
    assign bus_out = (state == CLEAR) ? '0 : mem[addr];
    assign bus_oe  = ram_out & ~prog_en & ~busy;

endmodule
